// File: rtl/sprite_bitmap_loader_pkg.sv
// Shared definitions for the sprite bitmap loader.
// Holds the frame constants (header byte, rows per sprite, row width),
// the row and row-index types, and the loader state encoding.
package sprite_bitmap_loader_pkg;

    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
    localparam int         ROW_COUNT     = 8;
    localparam int         ROW_W         = 8;
    localparam int         ROW_IDX_W     = $clog2(ROW_COUNT);

    typedef logic [ROW_W-1:0]     row_t;
    typedef logic [ROW_IDX_W-1:0] row_idx_t;

    // Loader states: hunt for header, collect rows, compare checksum,
    // hold a validated frame until vertical sync.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ROWS    = 2'd1,
        ST_CHECK   = 2'd2,
        ST_PENDING = 2'd3
    } state_t;

endpackage

// File: rtl/sprite_bitmap_loader_if.sv
// Byte-stream handshake between the serial front end and the loader.
// A byte transfers on every clk edge where inValid && inReady.
//   inByte  : stream data byte           (source -> loader)
//   inValid : inByte is valid this cycle (source -> loader)
//   inReady : loader can accept a byte   (loader -> source)
interface sprite_bitmap_loader_if;
    logic [7:0] inByte;
    logic       inValid;
    logic       inReady;

    modport master (output inByte, output inValid, input inReady);
    modport slave  (input inByte, input inValid, output inReady);
endinterface

// File: rtl/sprite_bitmap_bank.sv
// 8x8 sprite storage: a shadow bitmap filled row by row while a frame is
// received, and an active bitmap the renderer reads. A commit strobe copies
// all shadow rows into the active bitmap in a single cycle.
//   clk, rst_n        : clock, asynchronous active-low reset
//   wr_en/addr/data   : shadow row write port
//   commit            : bulk copy shadow -> active
//   rd_addr, rd_data  : registered active-row read (1-cycle latency)
module sprite_bitmap_bank
    import sprite_bitmap_loader_pkg::*;
(
    input  logic     clk,
    input  logic     rst_n,
    input  logic     wr_en,
    input  row_idx_t wr_addr,
    input  row_t     wr_data,
    input  logic     commit,
    input  row_idx_t rd_addr,
    output row_t     rd_data
);

    row_t shadow_mem [ROW_COUNT];
    row_t active_mem [ROW_COUNT];

    // NOTE: the arrays are plain flops (64 bits each), so they take the async
    // reset like any other register; a reset must blank the displayed sprite.
    // NOTE: non-blocking assignments make the read below see the pre-commit
    // active row, which is exactly the old-row-in-commit-cycle behaviour.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ROW_COUNT; i++) begin
                shadow_mem[i] <= '0;
                active_mem[i] <= '0;
            end
            rd_data <= '0;
        end else begin
            if (wr_en) begin
                shadow_mem[wr_addr] <= wr_data;
            end
            if (commit) begin
                for (int i = 0; i < ROW_COUNT; i++) begin
                    active_mem[i] <= shadow_mem[i];
                end
            end
            rd_data <= active_mem[rd_addr];
        end
    end

endmodule

// File: rtl/sprite_bitmap_loader.sv
// Framed sprite loader: parses SYNC_BYTE, row0..row7, checksum (XOR of the
// rows) from a byte stream, holds a validated frame in the shadow bitmap and
// commits it to the active bitmap on the next vSync rising edge.
//   clk, resetN   : clock, asynchronous active-low reset
//   in_bus        : byte-stream handshake (slave side)
//   vSync         : vertical sync, high during sync
//   rdRowAddr     : active bitmap row to read
//   rdRowData     : active row, bit 7 = leftmost pixel, 1-cycle latency
//   framePending  : validated frame waiting for commit
//   frameDone     : one-cycle pulse after a commit
//   frameError    : one-cycle pulse after checksum mismatch or timeout
module sprite_bitmap_loader
    import sprite_bitmap_loader_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEF,
    parameter int         TIMEOUT_CYCLES = 27000
) (
    input  logic                         clk,
    input  logic                         resetN,
    sprite_bitmap_loader_if.slave        in_bus,
    input  logic                         vSync,
    input  logic [2:0]                   rdRowAddr,
    output logic [7:0]                   rdRowData,
    output logic                         framePending,
    output logic                         frameDone,
    output logic                         frameError
);

    localparam int             TMO_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    state_t           state, state_nxt;
    row_idx_t         row_idx;
    row_t             xor_acc;
    logic [TMO_W-1:0] tmo_cnt;
    logic             vsync_q;

    logic in_ready, shadow_we, commit, err_set;
    logic accept, vsync_rise, in_frame, timed_out, cksum_ok, last_row;

    assign accept     = in_bus.inValid && in_ready;
    assign vsync_rise = vSync && !vsync_q;
    assign in_frame   = (state == ST_ROWS) || (state == ST_CHECK);
    assign timed_out  = in_frame && !accept && (tmo_cnt == TMO_LAST);
    assign cksum_ok   = (in_bus.inByte == xor_acc);
    // Termination compares the index instead of relying on a 7 -> 0 wrap.
    assign last_row   = (row_idx == row_idx_t'(ROW_COUNT - 1));

    // State register
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) state <= ST_IDLE;
        else         state <= state_nxt;
    end

    // Next-state logic
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: begin
                if (accept && in_bus.inByte == SYNC_BYTE) state_nxt = ST_ROWS;
            end
            ST_ROWS: begin
                if (timed_out)              state_nxt = ST_IDLE;
                else if (accept && last_row) state_nxt = ST_CHECK;
            end
            ST_CHECK: begin
                if (timed_out)   state_nxt = ST_IDLE;
                else if (accept) state_nxt = cksum_ok ? ST_PENDING : ST_IDLE;
            end
            ST_PENDING: begin
                // Only an edge seen while already PENDING commits, so a vSync
                // that rose with the checksum byte must fall and rise again.
                if (vsync_rise) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Output / strobe logic
    always_comb begin
        in_ready  = (state != ST_PENDING);
        shadow_we = (state == ST_ROWS) && accept;
        commit    = (state == ST_PENDING) && vsync_rise;
        err_set   = timed_out || ((state == ST_CHECK) && accept && !cksum_ok);
    end

    assign in_bus.inReady = in_ready;
    assign framePending   = (state == ST_PENDING);

    // Datapath: row index, checksum accumulator, inter-byte timeout, pulses
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            row_idx    <= '0;
            xor_acc    <= '0;
            tmo_cnt    <= '0;
            vsync_q    <= 1'b0;
            frameDone  <= 1'b0;
            frameError <= 1'b0;
        end else begin
            vsync_q    <= vSync;
            frameDone  <= commit;
            frameError <= err_set;

            if (state == ST_IDLE) begin
                row_idx <= '0;
                xor_acc <= '0;
            end else if (shadow_we) begin
                row_idx <= row_idx + row_idx_t'(1);
                xor_acc <= xor_acc ^ in_bus.inByte;
            end

            // Counts idle cycles inside a frame only; any transfer restarts it.
            if (in_frame && !accept && !timed_out) tmo_cnt <= tmo_cnt + TMO_W'(1);
            else                                    tmo_cnt <= '0;
        end
    end

    sprite_bitmap_bank u_bank (
        .clk     (clk),
        .rst_n   (resetN),
        .wr_en   (shadow_we),
        .wr_addr (row_idx),
        .wr_data (in_bus.inByte),
        .commit  (commit),
        .rd_addr (rdRowAddr),
        .rd_data (rdRowData)
    );

endmodule
